// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared constants and types for the pipeline stall/flush/freeze sequencer.
// The `define entries are the codebase-wide constants (FSM encodings, register index width).
// The package re-exports them as a typed state enum, a localparam and a register-compare helper.
// Ports: none (package).
`ifndef PIPELINE_CTRL_DEFINES
`define PIPELINE_CTRL_DEFINES
`define ST_RUN      2'd0
`define ST_MEM_WAIT 2'd1
`define ST_TIMEOUT  2'd2
`define REG_IDX_W   4
`endif

package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = `REG_IDX_W;

  typedef enum logic [1:0] {
    ST_RUN      = `ST_RUN,
    ST_MEM_WAIT = `ST_MEM_WAIT,
    ST_TIMEOUT  = `ST_TIMEOUT
  } state_t;

  // True when a writing stage targets the register read in ID (full 4-bit compare, R15 included).
  function automatic logic reg_match(input logic                 wr_en,
                                     input logic [REG_IDX_W-1:0] dest,
                                     input logic [REG_IDX_W-1:0] src);
    return wr_en & (dest == src);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect_unit.sv
// hazard_detect_unit: purely combinational RAW detection between the ID-stage sources
// and the EXE/MEM destinations.
// Build option: FORWARDING_EN -- when defined, only load-use hazards against EXE are flagged,
// since the forwarding unit supplies ALU results from EXE and MEM.
// Ports:
//   id_src1/id_src1_v, id_src2/id_src2_v : ID-stage source indices and their read enables
//   exe_dest/exe_wb_en/exe_mem_r_en      : EXE destination, write-back enable, load flag
//   mem_dest/mem_wb_en                   : MEM destination and write-back enable
//   raw                                  : a read-after-write hazard exists
module hazard_detect_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic                 id_src1_v,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_src2_v,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 raw
);

  logic match1_s;
  logic match2_s;
  logic unused_s;

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time; MEM results are always forwardable.
  assign match1_s = reg_match(exe_wb_en & exe_mem_r_en, exe_dest, id_src1);
  assign match2_s = reg_match(exe_wb_en & exe_mem_r_en, exe_dest, id_src2);
  assign unused_s = ^{mem_dest, mem_wb_en};
`else
  assign match1_s = reg_match(exe_wb_en, exe_dest, id_src1) | reg_match(mem_wb_en, mem_dest, id_src1);
  assign match2_s = reg_match(exe_wb_en, exe_dest, id_src2) | reg_match(mem_wb_en, mem_dest, id_src2);
  assign unused_s = exe_mem_r_en;
`endif

  assign raw = (id_src1_v & match1_s) | (id_src2_v & match2_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/freeze sequencer for the 5-stage pipeline.
// Owns the SRAM wait FSM (RUN / MEM_WAIT / TIMEOUT) with watchdog timer, the output
// priority mux (freeze > branch flush > RAW bubble) and a saturating stall-cycle counter.
// Build option: FORWARDING_EN (see hazard_detect_unit) selects load-use-only hazard detection.
// Ports:
//   clk, rst (async, active-low)
//   id_src*/exe_*/mem_dest/mem_wb_en : hazard detection inputs
//   exe_branch                       : taken branch resolved in EXE
//   mem_req, mem_ready               : SRAM handshake from the MEM stage
//   stall_clr                        : synchronous clear of stall_cycles
//   hazard, freeze_if, flush, freeze_pipe : same-cycle pipeline controls
//   mem_timeout                      : sticky SRAM watchdog error
//   stall_cycles                     : saturating count of stalled cycles
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_IDX_W-1:0]   id_src1,
  input  logic                   id_src1_v,
  input  logic [REG_IDX_W-1:0]   id_src2,
  input  logic                   id_src2_v,
  input  logic [REG_IDX_W-1:0]   exe_dest,
  input  logic                   exe_wb_en,
  input  logic                   exe_mem_r_en,
  input  logic [REG_IDX_W-1:0]   mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   exe_branch,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   stall_clr,
  output logic                   hazard,
  output logic                   freeze_if,
  output logic                   flush,
  output logic                   freeze_pipe,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [7:0]             TIMER_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX    = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE    = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [7:0]             timer_r;
  logic                   mem_timeout_r;
  logic [STALL_CNT_W-1:0] stall_cycles_r;
  logic                   raw_s;
  logic                   freeze_pipe_s;
  logic                   freeze_if_s;
  logic                   flush_s;
  logic                   hazard_s;

  hazard_detect_unit u_hazard_detect_unit (
    .id_src1      (id_src1),
    .id_src1_v    (id_src1_v),
    .id_src2      (id_src2),
    .id_src2_v    (id_src2_v),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .raw          (raw_s)
  );

  // Pipe freeze request derived from the SRAM FSM state and handshake.
  always_comb begin
    freeze_pipe_s = 1'b0;
    case (state_r)
      ST_RUN:      freeze_pipe_s = mem_req & ~mem_ready;
      ST_MEM_WAIT: freeze_pipe_s = ~mem_ready;
      ST_TIMEOUT:  freeze_pipe_s = 1'b1;
      default:     freeze_pipe_s = 1'b1;  // corrupted state: hold the pipe
    endcase
  end

  // Priority mux: a frozen pipe masks branches, and a squashing branch makes a RAW stall moot.
  always_comb begin
    freeze_if_s = 1'b0;
    flush_s     = 1'b0;
    hazard_s    = 1'b0;
    if (freeze_pipe_s) begin
      freeze_if_s = 1'b1;
    end else if (exe_branch) begin
      flush_s = 1'b1;
    end else if (raw_s) begin
      hazard_s    = 1'b1;
      freeze_if_s = 1'b1;
    end else begin
      freeze_if_s = 1'b0;
    end
  end

  // Controls are forced low while reset is asserted.
  assign freeze_pipe  = rst & freeze_pipe_s;
  assign freeze_if    = rst & freeze_if_s;
  assign flush        = rst & flush_s;
  assign hazard       = rst & hazard_s;
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_cycles_r;

  // SRAM wait FSM with watchdog; TIMEOUT is left only through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_RUN;
      timer_r       <= 8'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (freeze_pipe_s) begin
            state_r <= ST_MEM_WAIT;
            timer_r <= 8'd0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          // A ready on the boundary cycle still completes the access.
          if (mem_ready) begin
            state_r <= ST_RUN;
          end else if (timer_r == TIMER_LAST) begin
            state_r       <= ST_TIMEOUT;
            mem_timeout_r <= 1'b1;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        ST_TIMEOUT: begin
          state_r       <= ST_TIMEOUT;
          mem_timeout_r <= 1'b1;
        end
        default: begin
          state_r       <= ST_TIMEOUT;
          mem_timeout_r <= 1'b1;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= '0;
    end else if (stall_clr) begin
      stall_cycles_r <= '0;
    end else if ((freeze_if_s | freeze_pipe_s) && (stall_cycles_r != CNT_MAX)) begin
      stall_cycles_r <= stall_cycles_r + CNT_ONE;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

endmodule
